scmp_bus_responder: RTL and testbench

// Memory-side responder for the SC/MP external bus. Decodes bus cycles started by the CPU core
// (ADS_n / RD_n / WR_n), latches the 16-bit address and cycle flags, serves reads from a

---
 rtl/scmp_bus_responder.sv | 177 +++++++++++++++++
 tb/tb_scmp_bus_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scmp_bus_responder.sv
// scmp_bus_responder
// Memory-side responder for the SC/MP external bus. Decodes CPU bus cycles
// (ADS_n / RD_n / WR_n), latches the 16-bit address and cycle flags, serves
// reads from a fixed-latency synchronous memory port and commits writes once
// the write strobe is released. Also records halts and counts instruction fetches.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   addr[11:0]      CPU address A11:0 (valid while ADS_n low)
//   D_i[7:0]        {H,D,I,R,A15:12} during ADS_n, write data during WR_n
//   ADS_n/RD_n/WR_n active-low bus strobes
//   D_o, D_oe       read data to CPU and its drive enable
//   mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata  synchronous memory port
//   halt            sticky, set by a claimed cycle carrying H
//   fetch_cnt       claimed cycles carrying I (wrapping)
//   bus_err         one-cycle protocol-violation pulse
module scmp_bus_responder #(
  parameter logic [3:0]  PAGE_MASK  = 4'hF,
  parameter logic [3:0]  PAGE_MATCH = 4'h0,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic [7:0]  D_i,
  input  logic        ADS_n,
  input  logic        RD_n,
  input  logic        WR_n,
  output logic [7:0]  D_o,
  output logic        D_oe,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        halt,
  output logic [15:0] fetch_cnt,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RDWAIT, S_RDHOLD, S_WRHOLD, S_WRCOMMIT
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT);

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic [15:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        halt_q, halt_d;
  logic [15:0] fetch_q, fetch_d;
  logic        err_q, err_d;
  logic [2:0]  lat_q, lat_d;
  logic        both_low;

  // D and R flags carry no meaning for this responder.
  logic unused_flags;
  assign unused_flags = D_i[6] ^ D_i[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      halt_q  <= 1'b0;
      fetch_q <= '0;
      err_q   <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      halt_q  <= halt_d;
      fetch_q <= fetch_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    halt_d  = halt_q;
    fetch_d = fetch_q;
    lat_d   = lat_q;

    both_low = !RD_n && !WR_n;
    err_d    = both_low || (state_q == S_IDLE && ADS_n && (!RD_n || !WR_n));

    // Strobe collision outranks everything, including a new address strobe.
    if (both_low) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
    end else if (!ADS_n) begin
      addr_d  = {D_i[3:0], addr};
      sel_d   = (D_i[3:0] & PAGE_MASK) == PAGE_MATCH;
      if (sel_d && D_i[5]) fetch_d = fetch_q + 16'd1;
      if (sel_d && D_i[7]) halt_d = 1'b1;
      oe_d    = 1'b0;
      state_d = S_ADDR;
    end else begin
      unique case (state_q)
        S_ADDR: begin
          if (!sel_q) begin
            state_d = S_IDLE;
          end else if (!RD_n) begin
            rd_d    = 1'b1;
            lat_d   = '0;
            state_d = S_RDWAIT;
          end else if (!WR_n) begin
            wdata_d = D_i;
            state_d = S_WRHOLD;
          end
        end
        S_RDWAIT: begin
          // lat_q counts edges since mem_rd was visible; data is captured
          // MEM_LAT cycles after the request cycle.
          if (lat_q == LAT_LAST) begin
            dout_d  = mem_rdata;
            oe_d    = 1'b1;
            state_d = S_RDHOLD;
          end else begin
            lat_d = lat_q + 3'd1;
          end
        end
        S_RDHOLD: begin
          if (RD_n) begin
            oe_d    = 1'b0;
            state_d = S_IDLE;
          end
        end
        S_WRHOLD: begin
          if (!WR_n) begin
            wdata_d = D_i;
          end else begin
            wr_d    = 1'b1;
            state_d = S_WRCOMMIT;
          end
        end
        S_WRCOMMIT: state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  assign D_o       = dout_q;
  assign D_oe      = oe_q & ~RD_n;
  assign mem_addr  = addr_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_wdata = wdata_q;
  assign halt      = halt_q;
  assign fetch_cnt = fetch_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_scmp_bus_responder.sv
// tb_scmp_bus_responder
// Directed scenarios plus randomized bus transactions for scmp_bus_responder.
// A behavioural model tracks each bus cycle from the protocol rules and every
// output is compared on each falling clock edge.
module tb_scmp_bus_responder;

  localparam logic [3:0]  P_MASK  = 4'hE;  // pages 0 and 1 claimed
  localparam logic [3:0]  P_MATCH = 4'h0;
  localparam int unsigned P_LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] addr = '0;
  logic [7:0]  D_i = '0;
  logic        ADS_n = 1'b1, RD_n = 1'b1, WR_n = 1'b1;
  logic [7:0]  D_o;
  logic        D_oe;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        halt;
  logic [15:0] fetch_cnt;
  logic        bus_err;

  scmp_bus_responder #(.PAGE_MASK(P_MASK), .PAGE_MATCH(P_MATCH), .MEM_LAT(P_LAT)) dut (
    .clk(clk), .rst(rst), .addr(addr), .D_i(D_i), .ADS_n(ADS_n), .RD_n(RD_n),
    .WR_n(WR_n), .D_o(D_o), .D_oe(D_oe), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .fetch_cnt(fetch_cnt), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit rand_mem = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ph: 0 no cycle, 1 addressed, 2 read requested, 3 read data on bus,
  //     4 collecting write data, 5 write committing
  int          ph = 0;
  int unsigned tick = 0, rd_tick = 0;
  logic        m_sel = 1'b0;
  logic [7:0]  e_D_o = '0, e_wdata = '0;
  logic        e_oe = 1'b0, e_mem_rd = 1'b0, e_mem_wr = 1'b0, e_halt = 1'b0, e_bus_err = 1'b0;
  logic [15:0] e_mem_addr = '0, e_fetch = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; m_sel = 1'b0; e_D_o = '0; e_wdata = '0; e_oe = 1'b0;
      e_mem_rd = 1'b0; e_mem_wr = 1'b0; e_halt = 1'b0; e_bus_err = 1'b0;
      e_mem_addr = '0; e_fetch = '0;
    end else begin
      tick++;
      e_mem_rd  = 1'b0;
      e_mem_wr  = 1'b0;
      e_bus_err = (!RD_n && !WR_n) || (ph == 0 && ADS_n && (!RD_n || !WR_n));
      if (!RD_n && !WR_n) begin
        ph = 0; e_oe = 1'b0;
      end else if (!ADS_n) begin
        e_mem_addr = {D_i[3:0], addr};
        m_sel = ((D_i[3:0] & P_MASK) == P_MATCH);
        if (m_sel && D_i[5]) e_fetch = e_fetch + 16'd1;
        if (m_sel && D_i[7]) e_halt = 1'b1;
        e_oe = 1'b0;
        ph = 1;
      end else begin
        case (ph)
          1: if (!m_sel) ph = 0;
             else if (!RD_n) begin e_mem_rd = 1'b1; rd_tick = tick; ph = 2; end
             else if (!WR_n) begin e_wdata = D_i; ph = 4; end
          2: if (tick == rd_tick + P_LAT + 1) begin e_D_o = mem_rdata; e_oe = 1'b1; ph = 3; end
          3: if (RD_n) begin e_oe = 1'b0; ph = 0; end
          4: if (!WR_n) e_wdata = D_i;
             else begin e_mem_wr = 1'b1; ph = 5; end
          5: ph = 0;
          default: ph = 0;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare + event counters ----------------
  int          n_rd = 0, n_wr = 0, n_oe = 0;
  logic [15:0] last_rd_addr = '0;

  always @(negedge clk) begin
    chk("D_o",       32'(D_o),       32'(e_D_o));
    chk("D_oe",      32'(D_oe),      32'(e_oe & ~RD_n));
    chk("mem_addr",  32'(mem_addr),  32'(e_mem_addr));
    chk("mem_rd",    32'(mem_rd),    32'(e_mem_rd));
    chk("mem_wr",    32'(mem_wr),    32'(e_mem_wr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("halt",      32'(halt),      32'(e_halt));
    chk("fetch_cnt", 32'(fetch_cnt), 32'(e_fetch));
    chk("bus_err",   32'(bus_err),   32'(e_bus_err));
    chk("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
    if (mem_rd) begin n_rd++; last_rd_addr = mem_addr; end
    if (mem_wr) n_wr++;
    if (D_oe)   n_oe++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic ads, input logic rd, input logic wr,
                     input logic [7:0] di, input logic [11:0] a);
    ADS_n = ads; RD_n = rd; WR_n = wr; D_i = di; addr = a;
    if (rand_mem) mem_rdata = 8'($urandom);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1, 8'h00, 12'h000);
  endtask

  task automatic rand_txn();
    int unsigned k;
    logic [7:0]  di;
    k  = $urandom_range(0, 15);
    di = {4'($urandom), 4'($urandom_range(0, 3))};
    cyc(1'b0, 1'b1, 1'b1, di, 12'($urandom));
    repeat ($urandom_range(0, 2)) cyc(1'b1, 1'b1, 1'b1, 8'($urandom), 12'($urandom));
    if (k < 7) begin
      repeat ($urandom_range(1, 7)) cyc(1'b1, 1'b0, 1'b1, 8'($urandom), 12'($urandom));
    end else if (k < 13) begin
      repeat ($urandom_range(1, 4)) cyc(1'b1, 1'b1, 1'b0, 8'($urandom), 12'($urandom));
    end else if (k == 13) begin
      cyc(1'b1, 1'b0, 1'b0, 8'($urandom), 12'($urandom));
    end else begin
      cyc(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 12'($urandom));
    end
    // Zero idle cycles lets the next address strobe abort an open cycle.
    repeat ($urandom_range(0, 3)) cyc(1'b1, 1'b1, 1'b1, 8'($urandom), 12'($urandom));
  endtask

  initial begin
    int s_rd, s_wr, s_oe;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    chk("reset_fetch", 32'(fetch_cnt), 32'h0);
    chk("reset_D_oe",  32'(D_oe),      32'h0);

    // Read from page 0 with I flag
    mem_rdata = 8'h5A;
    s_rd = n_rd;
    cyc(1'b0, 1'b1, 1'b1, 8'h20, 12'h123);
    repeat (4) cyc(1'b1, 1'b0, 1'b1, 8'h00, 12'h000);
    chk("t1_D_o",  32'(D_o),  32'h5A);
    chk("t1_D_oe", 32'(D_oe), 32'h1);
    idle(1);
    chk("t1_D_oe_off", 32'(D_oe), 32'h0);
    chk("t1_nrd",   32'(n_rd - s_rd), 32'd1);
    chk("t1_raddr", 32'(last_rd_addr), 32'h0123);
    chk("t1_fetch", 32'(fetch_cnt), 32'h1);

    // Write to page 1, last write data wins
    s_wr = n_wr;
    cyc(1'b0, 1'b1, 1'b1, 8'h01, 12'h0FF);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 8'hC3, 12'h000);
    chk("t2_wr_early", 32'(mem_wr), 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 12'h000);
    chk("t2_wr",    32'(mem_wr),    32'h1);
    chk("t2_waddr", 32'(mem_addr),  32'h10FF);
    chk("t2_wdata", 32'(mem_wdata), 32'hC3);
    idle(1);
    chk("t2_nwr", 32'(n_wr - s_wr), 32'd1);

    // Unselected page 2 with H flag, then page 0 with H flag
    s_rd = n_rd; s_oe = n_oe;
    cyc(1'b0, 1'b1, 1'b1, 8'h82, 12'hABC);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 8'h00, 12'h000);
    idle(1);
    chk("t3_nrd",  32'(n_rd - s_rd), 32'd0);
    chk("t3_noe",  32'(n_oe - s_oe), 32'd0);
    chk("t3_halt", 32'(halt), 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 8'h80, 12'hABC);
    idle(3);
    chk("t3_halt_set", 32'(halt), 32'h1);

    // Abort during write collection
    s_wr = n_wr;
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 12'h111);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 8'hAA, 12'h000);
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 12'h222);
    cyc(1'b1, 1'b1, 1'b0, 8'hBB, 12'h000);
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 12'h000);
    chk("t4_wr",    32'(mem_wr),    32'h1);
    chk("t4_waddr", 32'(mem_addr),  32'h0222);
    chk("t4_wdata", 32'(mem_wdata), 32'hBB);
    idle(1);
    chk("t4_nwr", 32'(n_wr - s_wr), 32'd1);

    // Protocol errors
    s_rd = n_rd; s_wr = n_wr;
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 12'h333);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 12'h000);
    chk("t5_err_both", 32'(bus_err), 32'h1);
    idle(1);
    chk("t5_err_clr", 32'(bus_err), 32'h0);
    idle(2);
    chk("t5_noacc", 32'((n_rd - s_rd) + (n_wr - s_wr)), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 12'h000);
    chk("t5_err_idle", 32'(bus_err), 32'h1);
    idle(1);
    chk("t5_err_clr2", 32'(bus_err), 32'h0);

    // Reset while a read is waiting on memory
    cyc(1'b0, 1'b1, 1'b1, 8'h20, 12'h055);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 12'h000);
    rst = 1'b1;
    #1;
    chk("t6_rst_rd",    32'(mem_rd),    32'h0);
    chk("t6_rst_addr",  32'(mem_addr),  32'h0);
    chk("t6_rst_fetch", 32'(fetch_cnt), 32'h0);
    chk("t6_rst_halt",  32'(halt),      32'h0);
    chk("t6_rst_oe",    32'(D_oe),      32'h0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // fetch_cnt wrap
    for (int unsigned i = 0; i < 65535; i++) cyc(1'b0, 1'b1, 1'b1, 8'h20, 12'h000);
    chk("t6_fetch_max", 32'(fetch_cnt), 32'hFFFF);
    cyc(1'b0, 1'b1, 1'b1, 8'h20, 12'h000);
    chk("t6_fetch_wrap", 32'(fetch_cnt), 32'h0);
    idle(2);

    // Randomized transactions against the model
    rand_mem = 1'b1;
    for (int unsigned i = 0; i < 800; i++) rand_txn();
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
